// File: rtl/timing_defs_pkg.sv
// Shared phase encoding and default tick lengths for the STROB1/STROB2/GOT
// cycle-phase generator.
package timing_defs;

  typedef enum logic [2:0] {
    IDLE,
    S1,
    WOK,
    GAP,
    S2,
    GOT
  } state_t;

  localparam int DEF_STROB1_TICKS = 3;
  localparam int DEF_STROB2_TICKS = 2;
  localparam int DEF_GOT_TICKS    = 2;
  localparam int DEF_OK_TIMEOUT   = 8;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/strobe_seq_tick_cnt.sv
// Loadable down-counter shared by every timed phase; holds at zero.
module tick_cnt #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = val_i;
    else if (dec_i && (cnt_q != '0))
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/strobe_seq.sv
// Cycle-phase generator: active-low STROB1/STROB2/GOT pulses, STROB1 stretched
// while memory OK is outstanding, one-clock alarm on memory timeout.
module strobe_seq
  import timing_defs::*;
#(
  parameter int STROB1_TICKS = DEF_STROB1_TICKS,
  parameter int STROB2_TICKS = DEF_STROB2_TICKS,
  parameter int GOT_TICKS    = DEF_GOT_TICKS,
  parameter int OK_TIMEOUT   = DEF_OK_TIMEOUT
) (
  input  logic __clk,
  input  logic rst,
  input  logic run_en,
  input  logic sgot,
  input  logic mem_wait,
  input  logic ok,
  output logic strob1_,
  output logic strob2_,
  output logic got_,
  output logic busy,
  output logic alarm
);

  localparam int CW = $clog2(max4(STROB1_TICKS, STROB2_TICKS, GOT_TICKS, OK_TIMEOUT)) + 1;

  state_t         state_q, state_d;
  logic           load;
  logic [CW-1:0]  load_val;
  logic           cnt_zero;
  logic           alarm_d;
  logic           strob1_q, strob2_q, got_q, busy_q, alarm_q;

  tick_cnt #(.W(CW)) u_cnt (
    .clk_i  (__clk),
    .rst_i  (rst),
    .load_i (load),
    .val_i  (load_val),
    .dec_i  (state_q != IDLE),
    .zero_o (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_val = '0;
    alarm_d  = 1'b0;
    unique case (state_q)
      IDLE: if (run_en) begin
        state_d  = S1;
        load     = 1'b1;
        load_val = CW'(STROB1_TICKS - 1);
      end
      S1: if (cnt_zero) begin
        if (mem_wait && !ok) begin
          state_d  = WOK;
          load     = 1'b1;
          load_val = CW'(OK_TIMEOUT - 1);
        end else begin
          state_d = GAP;
        end
      end
      WOK: begin
        // ok takes priority over a timeout on the same clock
        if (ok) begin
          state_d = GAP;
        end else if (cnt_zero) begin
          state_d = GAP;
          alarm_d = 1'b1;
        end
      end
      GAP: begin
        load = 1'b1;
        if (sgot) begin
          state_d  = GOT;
          load_val = CW'(GOT_TICKS - 1);
        end else begin
          state_d  = S2;
          load_val = CW'(STROB2_TICKS - 1);
        end
      end
      S2: if (cnt_zero) begin
        state_d  = GOT;
        load     = 1'b1;
        load_val = CW'(GOT_TICKS - 1);
      end
      GOT: if (cnt_zero) begin
        if (run_en) begin
          state_d  = S1;
          load     = 1'b1;
          load_val = CW'(STROB1_TICKS - 1);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they switch on the same edge.
  always_ff @(posedge __clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      strob1_q <= 1'b1;
      strob2_q <= 1'b1;
      got_q    <= 1'b1;
      busy_q   <= 1'b0;
      alarm_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      strob1_q <= !((state_d == S1) || (state_d == WOK));
      strob2_q <= (state_d != S2);
      got_q    <= (state_d != GOT);
      busy_q   <= (state_d != IDLE);
      alarm_q  <= alarm_d;
    end
  end

  assign strob1_ = strob1_q;
  assign strob2_ = strob2_q;
  assign got_    = got_q;
  assign busy    = busy_q;
  assign alarm   = alarm_q;

endmodule

// File: tb/tb_strobe_seq.sv
// Directed bench for strobe_seq with default tick parameters (3/2/2/8).
module tb_strobe_seq;

  logic __clk = 1'b0;
  logic rst = 1'b1;
  logic run_en = 1'b0;
  logic sgot = 1'b0;
  logic mem_wait = 1'b0;
  logic ok = 1'b0;
  logic strob1_, strob2_, got_, busy, alarm;

  int checks = 0;
  int failures = 0;

  strobe_seq dut (
    .__clk    (__clk),
    .rst      (rst),
    .run_en   (run_en),
    .sgot     (sgot),
    .mem_wait (mem_wait),
    .ok       (ok),
    .strob1_  (strob1_),
    .strob2_  (strob2_),
    .got_     (got_),
    .busy     (busy),
    .alarm    (alarm)
  );

  always #5 __clk = ~__clk;

  // 0 = none low, 1 = STROB1, 2 = STROB2, 3 = GOT, 9 = illegal overlap
  function automatic int phase();
    case ({strob1_, strob2_, got_})
      3'b111:  return 0;
      3'b011:  return 1;
      3'b101:  return 2;
      3'b110:  return 3;
      default: return 9;
    endcase
  endfunction

  task automatic step();
    @(posedge __clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) step();
    checks++;
    if ({strob1_, strob2_, got_, busy, alarm} !== 5'b11100) begin
      failures++;
      $display("FAIL reset: s1=%b s2=%b got=%b busy=%b alarm=%b, want 1 1 1 0 0",
               strob1_, strob2_, got_, busy, alarm);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (phase() !== 0 || busy !== 1'b0 || alarm !== 1'b0) begin
        failures++;
        $display("FAIL idle[%0d]: phase=%0d busy=%b alarm=%b, want 0 0 0", i, phase(), busy, alarm);
      end
    end
  endtask

  task automatic test_single();
    int exp_ph [12] = '{1, 1, 1, 0, 3, 3, 1, 1, 1, 0, 3, 3};
    run_en = 1'b1; sgot = 1'b1; mem_wait = 1'b0; ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if (phase() !== exp_ph[i] || busy !== 1'b1 || alarm !== 1'b0) begin
        failures++;
        $display("FAIL single[%0d]: phase=%0d busy=%b alarm=%b, want phase=%0d busy=1 alarm=0",
                 i, phase(), busy, alarm, exp_ph[i]);
      end
    end
  endtask

  task automatic test_two_strobe();
    int exp_ph [16] = '{1, 1, 1, 0, 2, 2, 3, 3, 1, 1, 1, 0, 2, 2, 3, 3};
    sgot = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      checks++;
      if (phase() !== exp_ph[i] || busy !== 1'b1 || alarm !== 1'b0) begin
        failures++;
        $display("FAIL two_strobe[%0d]: phase=%0d busy=%b alarm=%b, want phase=%0d busy=1 alarm=0",
                 i, phase(), busy, alarm, exp_ph[i]);
      end
    end
  endtask

  task automatic test_mem_wait();
    int exp_ph [13] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 2, 2, 3, 3};
    mem_wait = 1'b1; ok = 1'b0;
    for (int i = 0; i < 13; i++) begin
      step();
      checks++;
      if (phase() !== exp_ph[i] || busy !== 1'b1 || alarm !== 1'b0) begin
        failures++;
        $display("FAIL mem_wait[%0d]: phase=%0d busy=%b alarm=%b, want phase=%0d busy=1 alarm=0",
                 i, phase(), busy, alarm, exp_ph[i]);
      end
      if (i == 7) ok = 1'b1;
      if (i == 8) ok = 1'b0;
    end
  endtask

  task automatic test_timeout();
    int   exp_ph [14];
    logic exp_al;
    for (int i = 0; i < 14; i++) exp_ph[i] = (i < 11) ? 1 : ((i == 11) ? 0 : 3);
    mem_wait = 1'b1; ok = 1'b0; sgot = 1'b1;
    for (int i = 0; i < 14; i++) begin
      step();
      exp_al = (i == 11);
      checks++;
      if (phase() !== exp_ph[i] || alarm !== exp_al) begin
        failures++;
        $display("FAIL timeout[%0d]: phase=%0d alarm=%b, want phase=%0d alarm=%b",
                 i, phase(), alarm, exp_ph[i], exp_al);
      end
    end
    mem_wait = 1'b0; sgot = 1'b0;
  endtask

  task automatic test_stop();
    int   exp_ph [11] = '{1, 1, 1, 0, 2, 2, 3, 3, 0, 0, 0};
    logic exp_busy;
    for (int i = 0; i < 11; i++) begin
      step();
      exp_busy = (i < 8);
      checks++;
      if (phase() !== exp_ph[i] || busy !== exp_busy || alarm !== 1'b0) begin
        failures++;
        $display("FAIL stop[%0d]: phase=%0d busy=%b alarm=%b, want phase=%0d busy=%b alarm=0",
                 i, phase(), busy, alarm, exp_ph[i], exp_busy);
      end
      if (i == 4) run_en = 1'b0;
    end
  endtask

  task automatic test_reset_mid_s2();
    run_en = 1'b1; sgot = 1'b0; mem_wait = 1'b0; ok = 1'b0;
    repeat (5) step();
    checks++;
    if (phase() !== 2) begin
      failures++;
      $display("FAIL rst_setup: phase=%0d, want 2", phase());
    end
    rst = 1'b1;
    #1;
    checks++;
    if (strob2_ !== 1'b1 || busy !== 1'b0 || alarm !== 1'b0 || phase() !== 0) begin
      failures++;
      $display("FAIL rst_async: s2=%b busy=%b alarm=%b phase=%0d, want 1 0 0 0",
               strob2_, busy, alarm, phase());
    end
    #1;
    rst = 1'b0;
    step();
    checks++;
    if (strob1_ !== 1'b0 || busy !== 1'b1 || phase() !== 1) begin
      failures++;
      $display("FAIL rst_restart: s1=%b busy=%b phase=%0d, want 0 1 1", strob1_, busy, phase());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_strobe();
    test_mem_wait();
    test_timeout();
    test_stop();
    test_reset_mid_s2();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
